// File: rtl/ucsbece154b_fetch_queue.sv
// ucsbece154b_fetch_queue: N-lane in-order instruction fetch queue between fetch and decode.
// Ports: clk, reset (async, active-high), flush_i (mispredict flush),
//   push_cnt_i/push_pc_i/push_instr_i/push_ready_o (fetch side, all-or-nothing bundles),
//   pop_cnt_i/pop_valid_o/pop_instr_o/pop_pc_o (decode side, lane 0 oldest),
//   count_o (registered occupancy), pop_err_o (sticky over-pop flag).
// Optional macro UCSBECE154B_FETCH_QUEUE_BYPASS_EN: an empty queue forwards an
//   accepted push to the pop lanes in the same cycle.
module ucsbece154b_fetch_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic [$clog2(LANES+1)-1:0] push_cnt_i,
  input  logic [XLEN-1:0]            push_pc_i,
  input  logic [LANES*XLEN-1:0]      push_instr_i,
  output logic                       push_ready_o,
  input  logic [$clog2(LANES+1)-1:0] pop_cnt_i,
  output logic [LANES-1:0]           pop_valid_o,
  output logic [LANES*XLEN-1:0]      pop_instr_o,
  output logic [LANES*XLEN-1:0]      pop_pc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       pop_err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, avail, acc_n, eff_pop;
  logic push_acc, over;
  assign count_o = count;
  assign push_ready_o = ({1'b0, count} + (CW+1)'(LANES)) <= (CW+1)'(DEPTH);
  assign push_acc = (push_cnt_i != '0) && push_ready_o && !flush_i;
  assign acc_n = push_acc ? CW'(push_cnt_i) : '0;
`ifdef UCSBECE154B_FETCH_QUEUE_BYPASS_EN
  logic byp;
  // popped bypass slots are still written at tail; head advances past them, so they never count
  assign byp = push_acc && (count == '0);
  assign avail = byp ? acc_n : count;
`else
  assign avail = count;
`endif
  assign over = CW'(pop_cnt_i) > avail;
  assign eff_pop = over ? avail : CW'(pop_cnt_i);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      pop_err_o <= 1'b0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(eff_pop);
      tail <= tail + PW'(acc_n);
      count <= count + acc_n - eff_pop;
      pop_err_o <= pop_err_o | over;
    end
  end
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (push_acc && CW'(j) < acc_n) begin
        pc_mem[tail + PW'(j)] <= push_pc_i + XLEN'(4 * j);
        ins_mem[tail + PW'(j)] <= push_instr_i[j*XLEN +: XLEN];
      end
    end
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [PW-1:0] idx;
    logic [XLEN-1:0] lane_pc, lane_ins;
    assign idx = head + PW'(k);
`ifdef UCSBECE154B_FETCH_QUEUE_BYPASS_EN
    assign lane_pc = byp ? push_pc_i + XLEN'(4 * k) : pc_mem[idx];
    assign lane_ins = byp ? push_instr_i[k*XLEN +: XLEN] : ins_mem[idx];
`else
    assign lane_pc = pc_mem[idx];
    assign lane_ins = ins_mem[idx];
`endif
    assign pop_valid_o[k] = CW'(k) < avail;
    assign pop_pc_o[k*XLEN +: XLEN] = pop_valid_o[k] ? lane_pc : '0;
    assign pop_instr_o[k*XLEN +: XLEN] = pop_valid_o[k] ? lane_ins : XLEN'(32'h0000_0013);
  end
endmodule

// File: tb/tb_ucsbece154b_fetch_queue.sv
// tb_ucsbece154b_fetch_queue: directed table-driven bench for the fetch queue (LANES=2, DEPTH=8).
module tb_ucsbece154b_fetch_queue;
  logic clk = 1'b0, reset = 1'b1, flush_i = 1'b0;
  logic [1:0] push_cnt_i = '0, pop_cnt_i = '0;
  logic [31:0] push_pc_i = '0;
  logic [63:0] push_instr_i = '0;
  logic push_ready_o, pop_err_o;
  logic [1:0] pop_valid_o;
  logic [63:0] pop_instr_o, pop_pc_o;
  logic [3:0] count_o;
  int total = 0, bad = 0;
  ucsbece154b_fetch_queue #(.LANES(2), .DEPTH(8), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .push_cnt_i(push_cnt_i),
    .push_pc_i(push_pc_i), .push_instr_i(push_instr_i), .push_ready_o(push_ready_o),
    .pop_cnt_i(pop_cnt_i), .pop_valid_o(pop_valid_o), .pop_instr_o(pop_instr_o),
    .pop_pc_o(pop_pc_o), .count_o(count_o), .pop_err_o(pop_err_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic fl; logic [1:0] n; logic [31:0] pc, i0, i1; logic [1:0] pop;
    logic [3:0] cnt; logic [1:0] val; logic rdy, err; logic [31:0] pc0, pc1, ins0;
  } vec_t;
  vec_t tv [18];
  function automatic logic [31:0] w(input logic [31:0] pc);
    return 32'hABC0_0000 | pc;
  endfunction
  function automatic vec_t mk(input logic fl, input logic [1:0] n, input logic [31:0] pc,
                              input logic [1:0] pop, input logic [3:0] cnt, input logic [1:0] val,
                              input logic rdy, input logic err, input logic [31:0] pc0,
                              input logic [31:0] pc1, input logic [31:0] ins0);
    vec_t v;
    v.fl = fl; v.n = n; v.pc = pc; v.i0 = w(pc); v.i1 = w(pc + 4); v.pop = pop;
    v.cnt = cnt; v.val = val; v.rdy = rdy; v.err = err; v.pc0 = pc0; v.pc1 = pc1; v.ins0 = ins0;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic idle();
    flush_i = 1'b0; push_cnt_i = '0; pop_cnt_i = '0; push_pc_i = '0; push_instr_i = '0;
  endtask
  task automatic step(input vec_t v, input int i);
    @(negedge clk);
    flush_i = v.fl; push_cnt_i = v.n; push_pc_i = v.pc; push_instr_i = {v.i1, v.i0}; pop_cnt_i = v.pop;
    @(posedge clk);
    #1 idle();
    #1;
    chk($sformatf("v%0d count", i), 32'(count_o), 32'(v.cnt));
    chk($sformatf("v%0d valid", i), 32'(pop_valid_o), 32'(v.val));
    chk($sformatf("v%0d ready", i), 32'(push_ready_o), 32'(v.rdy));
    chk($sformatf("v%0d err", i), 32'(pop_err_o), 32'(v.err));
    chk($sformatf("v%0d pc0", i), pop_pc_o[31:0], v.pc0);
    chk($sformatf("v%0d pc1", i), pop_pc_o[63:32], v.pc1);
    chk($sformatf("v%0d ins0", i), pop_instr_o[31:0], v.ins0);
  endtask
  initial begin
    tv[0]  = mk(0, 2, 32'h100, 0, 2, 3, 1, 0, 32'h100, 32'h104, 32'h0050_0093);
    tv[0].i0 = 32'h0050_0093; tv[0].i1 = 32'h0010_0113;
    tv[1]  = mk(0, 2, 32'h108, 0, 4, 3, 1, 0, 32'h100, 32'h104, 32'h0050_0093);
    tv[2]  = mk(0, 2, 32'h110, 0, 6, 3, 1, 0, 32'h100, 32'h104, 32'h0050_0093);
    tv[3]  = mk(0, 1, 32'h118, 0, 7, 3, 0, 0, 32'h100, 32'h104, 32'h0050_0093);
    tv[4]  = mk(0, 2, 32'h300, 0, 7, 3, 0, 0, 32'h100, 32'h104, 32'h0050_0093);
    tv[5]  = mk(0, 0, 32'h0,   2, 5, 3, 1, 0, 32'h108, 32'h10c, w(32'h108));
    tv[6]  = mk(0, 0, 32'h0,   2, 3, 3, 1, 0, 32'h110, 32'h114, w(32'h110));
    tv[7]  = mk(0, 0, 32'h0,   2, 1, 1, 1, 0, 32'h118, 32'h0,   w(32'h118));
    tv[8]  = mk(0, 0, 32'h0,   1, 0, 0, 1, 0, 32'h0,   32'h0,   32'h13);
    tv[9]  = mk(0, 2, 32'h200, 0, 2, 3, 1, 0, 32'h200, 32'h204, w(32'h200));
    tv[10] = mk(0, 0, 32'h0,   1, 1, 1, 1, 0, 32'h204, 32'h0,   w(32'h204));
    tv[11] = mk(0, 2, 32'h400, 0, 3, 3, 1, 0, 32'h204, 32'h400, w(32'h204));
    tv[12] = mk(0, 1, 32'h408, 0, 4, 3, 1, 0, 32'h204, 32'h400, w(32'h204));
    tv[13] = mk(1, 2, 32'h500, 2, 0, 0, 1, 0, 32'h0,   32'h0,   32'h13);
    tv[14] = mk(0, 1, 32'h600, 0, 1, 1, 1, 0, 32'h600, 32'h0,   w(32'h600));
    tv[15] = mk(0, 0, 32'h0,   2, 0, 0, 1, 1, 32'h0,   32'h0,   32'h13);
    tv[16] = mk(0, 2, 32'h700, 0, 2, 3, 1, 1, 32'h700, 32'h704, w(32'h700));
    tv[17] = mk(1, 0, 32'h0,   0, 0, 0, 1, 1, 32'h0,   32'h0,   32'h13);
    #2;
    chk("reset count", 32'(count_o), 0);
    chk("reset valid", 32'(pop_valid_o), 0);
    chk("reset ready", 32'(push_ready_o), 1);
    chk("reset err", 32'(pop_err_o), 0);
    #10 reset = 1'b0;
    for (int i = 0; i < 18; i++) step(tv[i], i);
    step(mk(0, 2, 32'h900, 0, 2, 3, 1, 1, 32'h900, 32'h904, w(32'h900)), 18);
    step(mk(0, 2, 32'h908, 0, 4, 3, 1, 1, 32'h900, 32'h904, w(32'h900)), 19);
    step(mk(0, 1, 32'h910, 0, 5, 3, 1, 1, 32'h900, 32'h904, w(32'h900)), 20);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset count", 32'(count_o), 0);
    chk("async reset valid", 32'(pop_valid_o), 0);
    chk("async reset ready", 32'(push_ready_o), 1);
    chk("async reset err", 32'(pop_err_o), 0);
    @(negedge clk);
    reset = 1'b0;
`ifdef UCSBECE154B_FETCH_QUEUE_BYPASS_EN
    @(negedge clk);
    push_cnt_i = 2; push_pc_i = 32'h800; push_instr_i = {w(32'h804), w(32'h800)}; pop_cnt_i = 2;
    #1;
    chk("bypass valid", 32'(pop_valid_o), 3);
    chk("bypass pc1", pop_pc_o[63:32], 32'h804);
    chk("bypass ins0", pop_instr_o[31:0], w(32'h800));
    @(posedge clk);
    #1 idle();
    #1;
    chk("bypass count", 32'(count_o), 0);
    chk("bypass err", 32'(pop_err_o), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ucsbece154b_fetch_queue.md
Name: ucsbece154b_fetch_queue

Overview:
- Parametrised N-lane instruction fetch queue. It sits between the fetch stage and the decode lanes of the superscalar pipeline.
- Generalises the fixed two-lane fetch-to-decode handoff to LANES lanes.
- Holds up to DEPTH {PC, instruction} entries. Accepts a bundle of up to LANES instructions per cycle and delivers up to LANES instructions per cycle, strictly in program order.
- Flushes in one cycle on a branch mispredict.

Parameters:
- LANES, 2, issue width: maximum instructions pushed and popped per cycle (1..4).
- DEPTH, 8, queue entries; power of two, DEPTH >= 2*LANES.
- XLEN, 32, PC and instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  mispredict flush; empties the queue.
- push_cnt_i  in  $clog2(LANES+1)  number of valid fetched words offered (0..LANES).
- push_pc_i  in  XLEN  PC of slot 0; slot k implied PC = push_pc_i + 4k.
- push_instr_i  in  LANES*XLEN  fetched words; slot k at bits [k*XLEN +: XLEN].
- push_ready_o  out  1  queue can accept a full LANES bundle this cycle.
- pop_cnt_i  in  $clog2(LANES+1)  number of instructions decode consumes this cycle.
- pop_valid_o  out  LANES  thermometer code: lane k valid when k < available.
- pop_instr_o  out  LANES*XLEN  instruction per decode lane; lane 0 is the oldest.
- pop_pc_o  out  LANES*XLEN  PC per decode lane.
- count_o  out  $clog2(DEPTH+1)  current occupancy (registered).
- pop_err_o  out  1  sticky: decode requested more instructions than were available.

Behaviour:
- Storage: circular buffer of DEPTH entries; head and tail pointers of width $clog2(DEPTH); count register. Pointers wrap modulo DEPTH.
- Reset (asynchronous):
  - head = tail = count = 0; pop_err_o = 0.
  - pop_valid_o = 0; push_ready_o = 1.
  - Storage contents are don't-care.
- push_ready_o = (DEPTH - count >= LANES). It uses registered count only; a same-cycle pop never raises it (no ready-to-pop combinational path).
- Push:
  - Accepted when push_cnt_i != 0, push_ready_o = 1 and flush_i = 0.
  - All push_cnt_i slots are written at tail, tail+1, ... with PC push_pc_i + 4k. tail advances by push_cnt_i. Partial acceptance never occurs.
  - A push offered while push_ready_o = 0 is dropped. Fetch must hold its PC.
- Available (no bypass) = count. Lane k outputs entry head+k when k < available.
- Invalid lanes drive instruction 0x00000013 (NOP) and PC 0.
- Pop:
  - Effective pop = min(pop_cnt_i, available). head advances by effective pop.
  - If pop_cnt_i > available, pop_err_o sets and stays set until reset.
- Simultaneous push and pop: count_next = count + accepted_push - effective_pop. Both pointers update in the same cycle.
- Flush has priority over push and pop. Next cycle: head = tail = count = 0. Any same-cycle push and pop are discarded. pop_err_o is not set by a flush cycle.
- Latency, bypass off: push in cycle t -> pop_valid_o in cycle t+1.
- Full (count = DEPTH): pop still allowed; push_ready_o = 0.
- Empty: pop_valid_o = 0. Any pop_cnt_i > 0 sets pop_err_o.
- Wrap-around: a bundle straddling index DEPTH-1 -> 0 stays contiguous in order on the pop lanes.

Optional Feature:
- Macro: UCSBECE154B_FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count = 0 and a push is accepted, the pushed slots appear on the pop lanes combinationally in the same cycle.
  - Available = accepted_push for that cycle. Popped bypass entries never occupy the queue: the tail write and the head advance cancel.
  - Remaining unpopped slots are stored normally.
  - Flush still blocks the bypass.
- Undefined: minimum latency is one cycle; no combinational push-to-pop path exists.

Test Plan (LANES=2, DEPTH=8):
- Reset mid-operation with count = 5 -> count_o = 0, pop_valid_o = 2'b00 and push_ready_o = 1 immediately, independent of clk.
- Push 2 words (0x00500093, 0x00100113) at PC 0x100, pop_cnt_i = 0 -> next cycle pop_valid_o = 2'b11, pop_pc_o = {0x104, 0x100}, count_o = 2.
- Fill to count = 7 -> push_ready_o = 0. A push of 2 words is dropped, count_o stays 7. Pop 2 -> count_o = 5 and push_ready_o = 1 the following cycle.
- head = 7, push 2 at PC 0x200, pop 1 -> lane 0 PC 0x200 (index 7), lane 1 PC 0x204 (index 0) on the next pop.
- count = 4, flush_i = 1 with simultaneous push 2 and pop 2 -> next cycle count_o = 0, pop_valid_o = 0, pop_err_o unchanged.
- count = 1, pop_cnt_i = 2 -> one entry consumed, count_o = 0, pop_err_o = 1 and held. With the bypass macro on: empty queue, push 2 and pop 2 in the same cycle -> pop_valid_o = 2'b11 that cycle and count_o stays 0.
